// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - symbolic RV32 instruction encoder and instruction-memory loader
// Two-stage pipeline: E holds the freshly encoded word, W drives the memory write port.
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 256,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [2:0]    kind_i,
  input  logic [6:0]    funct7_i,
  input  logic [2:0]    funct3_i,
  input  logic [4:0]    rd_i,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic [12:0]   imm_i,
  input  logic          clear_i,
  output logic          imem_we_o,
  output logic [31:0]   imem_addr_o,
  output logic [31:0]   imem_data_o,
  input  logic          imem_ready_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          err_o
);

  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  logic          e_valid_q, e_valid_d;
  logic [31:0]   e_data_q,  e_data_d;
  logic          w_valid_q, w_valid_d;
  logic [31:0]   w_data_q,  w_data_d;
  logic [CW-1:0] count_q,   count_d;
  logic          err_q,     err_d;

  logic [31:0]   enc_word;
  logic          req_bad;
  logic          e_move;
  logic          w_done;
  logic          accept;
  logic          accept_ok;
  logic [CW:0]   inflight;
  logic          full;

  // Each kind only places the fields it owns; anything else stays zero.
  always_comb begin
    enc_word = 32'h0;
    req_bad  = 1'b0;
    case (kind_i)
      3'd0: enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
      3'd1: enc_word = {imm_i[11:0], rs1_i, 3'b010, rd_i, OP_LW};
      3'd2: enc_word = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], OP_SW};
      3'd3: begin
        enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000,
                    imm_i[4:1], imm_i[11], OP_BEQ};
        req_bad  = imm_i[0];
      end
      3'd4: enc_word = {imm_i[11:0], rs1_i, 3'b000, rd_i, OP_ADDI};
      default: req_bad = 1'b1;
    endcase
  end

  assign e_move   = e_valid_q && (!w_valid_q || imem_ready_i);
  assign w_done   = w_valid_q && imem_ready_i;
  assign inflight = {1'b0, count_q} + {{CW{1'b0}}, e_valid_q} + {{CW{1'b0}}, w_valid_q};
  assign full     = (inflight == DEPTH_W);

  assign req_ready_o = !clear_i && !full && (!e_valid_q || e_move);
  assign accept      = req_valid_i && req_ready_o;
  assign accept_ok   = accept && !req_bad;

  always_comb begin
    e_valid_d = e_valid_q;
    e_data_d  = e_data_q;
    w_valid_d = w_valid_q;
    w_data_d  = w_data_q;
    count_d   = count_q;
    err_d     = err_q;
    if (clear_i) begin
      e_valid_d = 1'b0;
      w_valid_d = 1'b0;
      count_d   = '0;
      err_d     = 1'b0;
    end else begin
      if (accept && req_bad) begin
        err_d = 1'b1;
      end
      // E refills only when it is empty or handing its word to W this cycle.
      if (e_move || !e_valid_q) begin
        e_valid_d = accept_ok;
        if (accept_ok) begin
          e_data_d = enc_word;
        end
      end
      if (e_move) begin
        w_valid_d = 1'b1;
        w_data_d  = e_data_q;
      end else if (w_done) begin
        w_valid_d = 1'b0;
      end
      if (w_done) begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      e_valid_q <= 1'b0;
      e_data_q  <= 32'h0;
      w_valid_q <= 1'b0;
      w_data_q  <= 32'h0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      e_valid_q <= e_valid_d;
      e_data_q  <= e_data_d;
      w_valid_q <= w_valid_d;
      w_data_q  <= w_data_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  // The word in W always carries index count_q, since writes retire in order.
  assign imem_we_o   = w_valid_q;
  assign imem_data_o = w_data_q;
  assign imem_addr_o = BASE_ADDR + {{(30-CW){1'b0}}, count_q, 2'b00};
  assign count_o     = count_q;
  assign full_o      = full;
  assign err_o       = err_q;

endmodule
